// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execution unit and the ALU control decoder.
package alu_exec_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;

  // Operation codes produced by the ALU control decoder
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_COMP = 3'b001,
    ALU_AND  = 3'b010,
    ALU_XOR  = 3'b011,
    ALU_DIFF = 3'b100,
    ALU_SHL  = 3'b101,
    ALU_SHRL = 3'b110,
    ALU_SHRA = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_SCAN  = 2'b10,
    ST_DONE  = 2'b11
  } alu_state_e;

  // Behaviour of one iterative datapath step
  typedef enum logic [1:0] {
    IT_SHL  = 2'b00,
    IT_SHRL = 2'b01,
    IT_SHRA = 2'b10,
    IT_SCAN = 2'b11
  } iter_mode_e;

  function automatic iter_mode_e shift_mode(input alu_ctrl_e c);
    case (c)
      ALU_SHL:  return IT_SHL;
      ALU_SHRL: return IT_SHRL;
      default:  return IT_SHRA;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_unit_iter_step.sv
// One-bit-per-cycle shift/scan datapath: working register plus step counter.
// Shifts count down to the final step; scans count up as the bit index.
module alu_iter_step
  import alu_exec_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  iter_mode_e        mode_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CNT_W-1:0]  cnt_i,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] next_o,
  output logic [CNT_W-1:0]  cnt_o
);

  iter_mode_e        mode_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;

  // One-bit step of the working register for the captured mode
  always_comb begin
    next_o = data_q;
    case (mode_q)
      IT_SHL:  next_o = {data_q[DATA_W-2:0], 1'b0};
      IT_SHRL: next_o = {1'b0, data_q[DATA_W-1:1]};
      IT_SHRA: next_o = {data_q[DATA_W-1], data_q[DATA_W-1:1]};
      default: next_o = {1'b0, data_q[DATA_W-1:1]};
    endcase
  end

  // Working register and counter: load on accept, advance on step
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= IT_SCAN;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      mode_q <= mode_i;
      data_q <= data_i;
      cnt_q  <= cnt_i;
    end else if (step_i) begin
      data_q <= next_o;
      cnt_q  <= (mode_q == IT_SCAN) ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
    end
  end

  assign data_o = data_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ops, iterative shifts and lowest-difference
// scan, with registered result and flags and a one-cycle out_valid strobe.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        control,
  input  logic              select,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              sign
);

  alu_state_e        state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              carry_q, carry_d;
  logic              zero_q, sign_q;
  logic              upd;

  logic              it_load, it_step;
  iter_mode_e        it_mode;
  logic [DATA_W-1:0] it_ld_data, it_data, it_next;
  logic [CNT_W-1:0]  it_ld_cnt, it_cnt;

  alu_ctrl_e         ctrl;
  logic [4:0]        amt;
  logic [DATA_W:0]   sum;

  assign ctrl = alu_ctrl_e'(control);
  assign amt  = select ? shamt : b[4:0];
  assign sum  = {1'b0, a} + {1'b0, b};

  alu_iter_step u_iter (
    .clk    (clk),
    .rst    (rst),
    .load_i (it_load),
    .step_i (it_step),
    .mode_i (it_mode),
    .data_i (it_ld_data),
    .cnt_i  (it_ld_cnt),
    .data_o (it_data),
    .next_o (it_next),
    .cnt_o  (it_cnt)
  );

  // Next state, datapath control and the value latched on entry to DONE
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    carry_d    = carry_q;
    upd        = 1'b0;
    it_load    = 1'b0;
    it_step    = 1'b0;
    it_mode    = IT_SCAN;
    it_ld_data = a ^ b;
    it_ld_cnt  = '0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          case (ctrl)
            ALU_ADD: begin
              result_d = sum[DATA_W-1:0];
              carry_d  = sum[DATA_W];
              upd      = 1'b1;
              state_d  = ST_DONE;
            end
            ALU_COMP: begin
              result_d = ~b + DATA_W'(1);
              carry_d  = (b == '0);
              upd      = 1'b1;
              state_d  = ST_DONE;
            end
            ALU_AND: begin
              result_d = a & b;
              carry_d  = 1'b0;
              upd      = 1'b1;
              state_d  = ST_DONE;
            end
            ALU_XOR: begin
              result_d = a ^ b;
              carry_d  = 1'b0;
              upd      = 1'b1;
              state_d  = ST_DONE;
            end
            ALU_DIFF: begin
              it_load = 1'b1;
              state_d = ST_SCAN;
            end
            default: begin
              if (amt == '0) begin
                result_d = a;
                carry_d  = 1'b0;
                upd      = 1'b1;
                state_d  = ST_DONE;
              end else begin
                it_load    = 1'b1;
                it_mode    = shift_mode(ctrl);
                it_ld_data = a;
                it_ld_cnt  = amt;
                state_d    = ST_SHIFT;
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        it_step = 1'b1;
        // Final step: capture the shifted value directly rather than waiting a cycle
        if (it_cnt == CNT_W'(1)) begin
          result_d = it_next;
          carry_d  = 1'b0;
          upd      = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_SCAN: begin
        if (it_data[0]) begin
          result_d = DATA_W'(it_cnt);
          carry_d  = 1'b0;
          upd      = 1'b1;
          state_d  = ST_DONE;
        end else if (it_cnt == CNT_W'(DATA_W - 1)) begin
          result_d = DATA_W'(DATA_W);
          carry_d  = 1'b0;
          upd      = 1'b1;
          state_d  = ST_DONE;
        end else begin
          it_step = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, result and flag registers; reset overrides any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (upd) begin
        result_q <= result_d;
        carry_q  <= carry_d;
        zero_q   <= (result_d == '0);
        sign_q   <= result_d[DATA_W-1];
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign sign      = sign_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases, back-pressure,
// reset abort and randomized operations against a behavioural model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  control;
  logic        select;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic [31:0] result;
  logic        carry, zero, sign;

  int total = 0;
  int bad   = 0;

  alu_exec_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .control   (control),
    .select    (select),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .sign      (sign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: result, carry and cycles from accept to out_valid
  task automatic model(input logic [2:0] c, input logic s, input logic [31:0] a_,
                       input logic [31:0] b_, input logic [4:0] sh_,
                       output logic [31:0] r, output logic cy, output int lat);
    int n;
    logic [32:0] wide;
    logic [31:0] d;
    n   = s ? int'(sh_) : int'(b_[4:0]);
    cy  = 1'b0;
    lat = 1;
    r   = '0;
    case (c)
      3'd0: begin wide = {1'b0, a_} + {1'b0, b_}; r = wide[31:0]; cy = wide[32]; end
      3'd1: begin r = 32'd0 - b_; cy = (b_ == 32'd0); end
      3'd2: r = a_ & b_;
      3'd3: r = a_ ^ b_;
      3'd4: begin
        d = a_ ^ b_;
        r = 32; lat = 33;
        for (int i = 31; i >= 0; i--)
          if (d[i]) begin r = i; lat = i + 2; end
      end
      3'd5: begin r = a_ << n; lat = (n == 0) ? 1 : n + 1; end
      3'd6: begin r = a_ >> n; lat = (n == 0) ? 1 : n + 1; end
      default: begin r = $signed(a_) >>> n; lat = (n == 0) ? 1 : n + 1; end
    endcase
  endtask

  task automatic run_op(input string tag, input logic [2:0] c, input logic s,
                        input logic [31:0] a_, input logic [31:0] b_, input logic [4:0] sh_);
    logic [31:0] er;
    logic        ec;
    int          lat, k;
    logic        got;
    model(c, s, a_, b_, sh_, er, ec, lat);
    @(negedge clk);
    control = c; select = s; a = a_; b = b_; shamt = sh_; in_valid = 1'b1;
    #1 chk({tag, "/in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0; got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (out_valid) got = 1'b1;
    end
    chk({tag, "/latency"}, 64'(got ? k : 0), 64'(lat));
    chk({tag, "/result"}, 64'(result), 64'(er));
    chk({tag, "/carry"}, 64'(carry), 64'(ec));
    chk({tag, "/zero"}, 64'(zero), 64'(er == 32'd0));
    chk({tag, "/sign"}, 64'(sign), 64'(er[31]));
    @(negedge clk);
    chk({tag, "/strobe_end"}, 64'(out_valid), 64'(0));
    chk({tag, "/ready_back"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    int ov_cnt;
    logic [2:0]  rc;
    logic [31:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; control = '0; select = 1'b0;
    a = '0; b = '0; shamt = '0;
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    chk("rst/in_ready", 64'(in_ready), 64'(0));
    chk("rst/out_valid", 64'(out_valid), 64'(0));
    chk("rst/result", 64'(result), 64'(0));
    chk("rst/flags", 64'({carry, zero, sign}), 64'(0));
    in_valid = 1'b0;
    rst = 1'b0;
    #1 chk("rst/ready_after", 64'(in_ready), 64'(1));

    run_op("add_wrap", 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd0);
    run_op("shra4", 3'd7, 1'b1, 32'h8000_0000, 32'h0, 5'd4);
    run_op("shl_b", 3'd5, 1'b0, 32'h1, 32'h25, 5'd0);
    run_op("diff4", 3'd4, 1'b0, 32'h10, 32'h0, 5'd0);
    run_op("diff_eq", 3'd4, 1'b0, 32'h1234, 32'h1234, 5'd0);
    run_op("diff_b31", 3'd4, 1'b0, 32'h8000_0000, 32'h0, 5'd0);
    run_op("comp0", 3'd1, 1'b0, 32'h5, 32'h0, 5'd0);
    run_op("comp1", 3'd1, 1'b0, 32'h5, 32'h1, 5'd0);
    run_op("and", 3'd2, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
    run_op("xor", 3'd3, 1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0);
    run_op("shrl0", 3'd6, 1'b1, 32'h8765_4321, 32'h3, 5'd0);
    run_op("shrl31", 3'd6, 1'b1, 32'h8765_4321, 32'h0, 5'd31);

    // Back-pressure: second request held during an active SHRL
    @(negedge clk);
    control = 3'd6; select = 1'b1; shamt = 5'd5; a = 32'hF0F0_0000; b = 32'h0; in_valid = 1'b1;
    #1 chk("hold/ready0", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 control = 3'd0; a = 32'h1111_1111; b = 32'h2222_2222;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("hold/busy_ov", 64'(out_valid), 64'(0));
      chk("hold/busy_rdy", 64'(in_ready), 64'(0));
    end
    @(negedge clk);
    chk("hold/first_ov", 64'(out_valid), 64'(1));
    chk("hold/first_rdy", 64'(in_ready), 64'(0));
    chk("hold/first_res", 64'(result), 64'(32'h0787_8000));
    @(negedge clk);
    chk("hold/idle_ov", 64'(out_valid), 64'(0));
    chk("hold/idle_rdy", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("hold/second_ov", 64'(out_valid), 64'(1));
    chk("hold/second_res", 64'(result), 64'(32'h3333_3333));
    @(negedge clk);
    chk("hold/second_end", 64'(out_valid), 64'(0));

    // Reset during the third SHIFT cycle of SHL by 10
    @(negedge clk);
    control = 3'd5; select = 1'b1; shamt = 5'd10; a = 32'h1; b = 32'h0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("abort/rdy_in_rst", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort/rdy_after", 64'(in_ready), 64'(1));
    chk("abort/result", 64'(result), 64'(0));
    ov_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    chk("abort/no_strobe", 64'(ov_cnt), 64'(0));

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      rc = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if (rc == 3'd4 && $urandom_range(0, 2) == 0) rb = ra ^ (32'h1 << $urandom_range(0, 31));
      if (rc == 3'd4 && $urandom_range(0, 5) == 0) rb = ra;
      if (rc == 3'd1 && $urandom_range(0, 4) == 0) rb = 32'h0;
      run_op("rand", rc, 1'($urandom_range(0, 1)), ra, rb, 5'($urandom_range(0, 31)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have the port: clk, input, 1 bit; single clock, all state updates on rising edge.
REQ-002 SHALL have the port: rst, input, 1 bit; synchronous, active-high reset.
REQ-003 SHALL have the port: in_valid, input, 1 bit; operation request.
REQ-004 SHALL have the port: in_ready, output, 1 bit; unit can accept an operation.
REQ-005 SHALL have the port: control, input, 3 bits; operation code from the ALU control decoder.
REQ-006 SHALL have the port: select, input, 1 bit; shift-amount source, 1 = shamt, 0 = b[4:0].
REQ-007 SHALL have the port: a, input, 32 bits; operand A and shift source.
REQ-008 SHALL have the port: b, input, 32 bits; operand B.
REQ-009 SHALL have the port: shamt, input, 5 bits; immediate shift amount.
REQ-010 SHALL have the port: out_valid, output, 1 bit; one-cycle result strobe.
REQ-011 SHALL have the port: result, output, 32 bits; registered result.
REQ-012 SHALL have the ports carry, zero and sign, output, 1 bit each; registered flags.

Function
REQ-013 SHALL decode control as 000 ADD (a+b), 001 COMP (~b+1), 010 AND, 011 XOR, 100 DIFF, 101 SHL, 110 SHRL, 111 SHRA; all shifts operate on a.
REQ-014 SHALL accept an operation in cycle C only when in_valid and in_ready are both 1, capturing control, select, a, b and shamt; in_valid while in_ready=0 is ignored.
REQ-015 SHALL drive in_ready=1 only in state IDLE and only while rst=0.
REQ-016 SHALL implement states IDLE, SHIFT, SCAN and DONE; DONE always returns to IDLE on the next cycle.
REQ-017 SHALL move ADD, COMP, AND, XOR, and any shift with amount 0, from IDLE to DONE; out_valid SHALL be 1 in cycle C+1.
REQ-018 SHALL move a shift with amount n>0 from IDLE to SHIFT, shift one bit per cycle for n cycles, then go to DONE; out_valid SHALL be 1 in cycle C+n+1.
REQ-019 SHALL zero-fill for SHL and SHRL, and SHALL replicate a[31] into the vacated bit for SHRA.
REQ-020 SHALL make DIFF return the index of the lowest set bit of a^b, or 32 when a==b.
REQ-021 SHALL move DIFF from IDLE to SCAN and test one bit per cycle from bit 0; for found index i, out_valid SHALL be 1 in cycle C+i+2, and for a==b in cycle C+33.
REQ-022 SHALL set carry to bit 32 of the 33-bit sum for ADD, to 1 for COMP only when b==0, and to 0 for all other operations.
REQ-023 SHALL set zero to (result==0) and sign to result[31].
REQ-024 SHALL update result and flags only on entry to DONE and hold them until the next DONE.
REQ-025 SHALL keep out_valid=1 for exactly one cycle, the DONE cycle.
REQ-026 SHALL use wrap-around, modulo 2^32 arithmetic throughout; no exception is raised on overflow.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, force the state to IDLE and set result=0, carry=0, zero=0, sign=0 and out_valid=0, including mid-SHIFT or mid-SCAN.
REQ-028 SHALL discard an operation that reset interrupts; no out_valid is produced for it.
REQ-029 SHALL give rst priority over in_valid in the same cycle.
REQ-030 SHALL drive in_ready=1 in the first cycle after rst is deasserted.

Structure
REQ-031 SHALL take the control-code constants, the state encoding and the data width (32) from a shared package, which the ALU control decoder also uses.
REQ-032 SHALL place the iterative shift/scan datapath (one-bit step and counter) in a sub-module, alu_iter_step, with the FSM and flags kept in alu_exec_unit.

Verification
REQ-033 SHALL be verified with: ADD a=0xFFFFFFFF, b=0x1 -> at C+1: result 0x0, carry 1, zero 1, sign 0.
REQ-034 SHALL be verified with: SHRA a=0x80000000, select=1, shamt=4 -> at C+5: result 0xF8000000, sign 1; SHL a=0x1, select=0, b=0x25 -> at C+6: result 0x20.
REQ-035 SHALL be verified with: DIFF a=0x10, b=0x0 -> at C+6: result 4; DIFF a=b=0x1234 -> at C+33: result 32.
REQ-036 SHALL be verified with: COMP b=0x0 -> result 0x0, carry 1, zero 1; COMP b=0x1 -> result 0xFFFFFFFF, carry 0, sign 1.
REQ-037 SHALL be verified with: rst pulsed during the 3rd cycle of SHL shamt=10 -> no out_valid, in_ready=1 the cycle after rst deasserts, result 0.
REQ-038 SHALL be verified with: in_valid held high with new operands during an active SHRL -> only the first operation completes, and the second is accepted only after return to IDLE.
